// File: rtl/baser_257b_check_ctrl.sv
// Window controller for the 257b block checker.
// Holds the checker in reset, runs it for a programmed number of blocks,
// snapshots its counters and presents a pass/mismatch verdict behind a
// valid/ready handshake. A window can be aborted before its report.
module baser_257b_check_ctrl #(
  parameter int CNT_WIDTH    = 32,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [CNT_WIDTH-1:0] i_window_len,
  input  logic [CNT_WIDTH-1:0] i_err_threshold,
  input  logic [CNT_WIDTH-1:0] i_block_count,
  input  logic [CNT_WIDTH-1:0] i_data_count,
  input  logic [CNT_WIDTH-1:0] i_ctrl_count,
  input  logic [CNT_WIDTH-1:0] i_inv_block_count,
  output logic                 o_chk_rst,
  output logic                 o_busy,
  output logic [CNT_WIDTH-1:0] o_res_blocks,
  output logic [CNT_WIDTH-1:0] o_res_data,
  output logic [CNT_WIDTH-1:0] o_res_ctrl,
  output logic [CNT_WIDTH-1:0] o_res_inv,
  output logic                 o_pass,
  output logic                 o_mismatch,
  output logic                 o_result_valid,
  input  logic                 i_result_ready,
  output logic                 o_aborted
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    LATCH  = 3'd3,
    REPORT = 3'd4
  } state_t;

  // Last value of the phase counter while in CLEAR.
  localparam logic [CNT_WIDTH-1:0] CLR_LAST = CNT_WIDTH'(CLEAR_CYCLES - 1);

  state_t               state, state_d;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] len_q;
  logic [CNT_WIDTH-1:0] thr_q;
  logic                 start_acc;
  logic                 abort_acc;
  logic                 do_latch;
  logic                 cnt_run;
  logic [CNT_WIDTH:0]   dc_sum;
  logic                 mis_d;
  logic                 pass_d;

  // Next-state decode; abort outranks every other exit from the busy states.
  always_comb begin
    state_d   = state;
    start_acc = 1'b0;
    abort_acc = 1'b0;
    do_latch  = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          state_d   = CLEAR;
          start_acc = 1'b1;
        end
      end
      CLEAR: begin
        if (i_abort) begin
          state_d   = IDLE;
          abort_acc = 1'b1;
        end else if (cnt == CLR_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (i_abort) begin
          state_d   = IDLE;
          abort_acc = 1'b1;
        end else if (cnt == len_q - 1'b1) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        if (i_abort) begin
          state_d   = IDLE;
          abort_acc = 1'b1;
        end else begin
          state_d  = REPORT;
          do_latch = 1'b1;
        end
      end
      REPORT: begin
        if (i_result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Phase counter advances only while staying in CLEAR or RUN; it restarts at
  // every state change, so in RUN it peaks at len-1 and never wraps.
  assign cnt_run = (state_d == state) && ((state == CLEAR) || (state == RUN));

  // Verdict from the live checker counters, registered at the end of LATCH.
  // The data+ctrl sum is one bit wider so it cannot alias back onto blocks.
  assign dc_sum = {1'b0, i_data_count} + {1'b0, i_ctrl_count};
  assign mis_d  = (i_block_count != len_q) || (dc_sum != {1'b0, i_block_count});
  assign pass_d = (i_inv_block_count <= thr_q) && !mis_d;

  // State, phase counter and captured window configuration.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      len_q <= '0;
      thr_q <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_run ? cnt + 1'b1 : '0;
      if (start_acc) begin
        // A zero length would never reach LATCH; run a single block instead.
        len_q <= (i_window_len == '0) ? CNT_WIDTH'(1) : i_window_len;
        thr_q <= i_err_threshold;
      end
    end
  end

  // Checker reset is released exactly for the RUN and LATCH states, so the
  // block count seen during LATCH equals the window length.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_chk_rst <= 1'b1;
      o_aborted <= 1'b0;
    end else begin
      o_chk_rst <= !((state_d == RUN) || (state_d == LATCH));
      o_aborted <= abort_acc;
    end
  end

  // Result snapshot; held through REPORT and afterwards until the next LATCH.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_res_blocks <= '0;
      o_res_data   <= '0;
      o_res_ctrl   <= '0;
      o_res_inv    <= '0;
      o_pass       <= 1'b0;
      o_mismatch   <= 1'b0;
    end else if (do_latch) begin
      o_res_blocks <= i_block_count;
      o_res_data   <= i_data_count;
      o_res_ctrl   <= i_ctrl_count;
      o_res_inv    <= i_inv_block_count;
      o_pass       <= pass_d;
      o_mismatch   <= mis_d;
    end
  end

  assign o_busy         = (state == CLEAR) || (state == RUN) || (state == LATCH);
  assign o_result_valid = (state == REPORT);

endmodule

// File: tb/tb_baser_257b_check_ctrl.sv
// Directed bench for baser_257b_check_ctrl with a window-level reference model
// and a small behavioural stand-in for the 257b checker.
module tb_baser_257b_check_ctrl;
  localparam int W = 32;
  localparam int C = 2;

  logic         clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic         i_abort = 1'b0;
  logic         i_result_ready = 1'b0;
  logic [W-1:0] i_window_len = '0;
  logic [W-1:0] i_err_threshold = '0;
  logic [W-1:0] blk = '0, dat = '0, ctl = '0, inv = '0;
  logic         o_chk_rst, o_busy, o_pass, o_mismatch, o_result_valid, o_aborted;
  logic [W-1:0] o_res_blocks, o_res_data, o_res_ctrl, o_res_inv;

  int n_vec = 0;
  int n_err = 0;
  int low_cnt = 0;
  int ab_cnt = 0;
  logic [1:0] kind [64];   // 0 data, 1 ctrl, 2 corrupted data, 3 unclassified

  always #5 clk = ~clk;

  baser_257b_check_ctrl #(.CNT_WIDTH(W), .CLEAR_CYCLES(C)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_window_len(i_window_len), .i_err_threshold(i_err_threshold),
    .i_block_count(blk), .i_data_count(dat), .i_ctrl_count(ctl),
    .i_inv_block_count(inv), .o_chk_rst(o_chk_rst), .o_busy(o_busy),
    .o_res_blocks(o_res_blocks), .o_res_data(o_res_data), .o_res_ctrl(o_res_ctrl),
    .o_res_inv(o_res_inv), .o_pass(o_pass), .o_mismatch(o_mismatch),
    .o_result_valid(o_result_valid), .i_result_ready(i_result_ready),
    .o_aborted(o_aborted)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Checker stand-in: one block per cycle while out of reset.
  always @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n || o_chk_rst) begin
      blk <= '0; dat <= '0; ctl <= '0; inv <= '0;
    end else begin
      blk <= blk + 1'b1;
      case (kind[blk[5:0]])
        2'd0: dat <= dat + 1'b1;
        2'd1: ctl <= ctl + 1'b1;
        2'd2: begin dat <= dat + 1'b1; inv <= inv + 1'b1; end
        default: ;
      endcase
    end
  end

  always @(posedge clk) if (i_rst_n && !o_chk_rst) low_cnt++;
  always @(posedge clk) if (o_aborted) ab_cnt++;

  // Reference model: m_t is the cycle index since the accepted start.
  // Cycles 0..C-1 clear, C..C+L-1 run, C+L latch, beyond that report.
  bit     m_on = 0;
  longint m_t = 0, m_len = 0, m_thr = 0;
  longint e_blk = 0, e_dat = 0, e_ctl = 0, e_inv = 0;
  longint r_blk = 0, r_dat = 0, r_ctl = 0, r_inv = 0;
  bit     r_pass = 0, r_mis = 0, e_ab = 0;

  always @(posedge clk) begin
    if (!i_rst_n) begin
      m_on = 0; e_ab = 0;
      r_blk = 0; r_dat = 0; r_ctl = 0; r_inv = 0; r_pass = 0; r_mis = 0;
    end else begin
      e_ab = 0;
      if (!m_on) begin
        if (i_start) begin
          m_on = 1; m_t = 0;
          m_len = (i_window_len == 0) ? 1 : longint'(i_window_len);
          m_thr = longint'(i_err_threshold);
          e_blk = m_len; e_dat = 0; e_ctl = 0; e_inv = 0;
          for (int i = 0; i < m_len && i < 64; i++) begin
            if (kind[i] == 2'd0 || kind[i] == 2'd2) e_dat++;
            if (kind[i] == 2'd1) e_ctl++;
            if (kind[i] == 2'd2) e_inv++;
          end
        end
      end else if (m_t <= C + m_len) begin
        if (i_abort) begin
          m_on = 0; e_ab = 1;
        end else begin
          if (m_t == C + m_len) begin
            r_blk = e_blk; r_dat = e_dat; r_ctl = e_ctl; r_inv = e_inv;
            r_mis = (e_blk != m_len) || (e_dat + e_ctl != e_blk);
            r_pass = (e_inv <= m_thr) && !r_mis;
          end
          m_t++;
        end
      end else if (i_result_ready) begin
        m_on = 0;
      end
    end
    #1;
    chk("busy", o_busy, m_on && m_t <= C + m_len);
    chk("valid", o_result_valid, m_on && m_t > C + m_len);
    chk("chk_rst", o_chk_rst, !(m_on && m_t >= C && m_t <= C + m_len));
    chk("aborted", o_aborted, e_ab);
    chk("res_blocks", o_res_blocks, r_blk);
    chk("res_data", o_res_data, r_dat);
    chk("res_ctrl", o_res_ctrl, r_ctl);
    chk("res_inv", o_res_inv, r_inv);
    chk("pass", o_pass, r_pass);
    chk("mismatch", o_mismatch, r_mis);
  end

  task automatic clr_kinds();
    for (int i = 0; i < 64; i++) kind[i] = 2'd0;
  endtask

  task automatic do_start(input int len, input int thr);
    i_start = 1'b1; i_window_len = W'(len); i_err_threshold = W'(thr);
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_valid();
    for (int k = 0; k < 200 && !o_result_valid; k++) @(negedge clk);
    chk("valid_timeout", o_result_valid, 1);
  endtask

  task automatic handshake();
    i_result_ready = 1'b1;
    @(negedge clk);
    i_result_ready = 1'b0;
    chk("hs_idle_valid", o_result_valid, 0);
    chk("hs_idle_busy", o_busy, 0);
  endtask

  initial begin
    int lo0, a0;
    clr_kinds();
    repeat (3) @(negedge clk);
    chk("rst_chk_rst", o_chk_rst, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", o_result_valid, 0);
    chk("rst_res_blocks", o_res_blocks, 0);
    chk("rst_pass", o_pass, 0);
    i_rst_n = 1'b1;
    @(negedge clk);

    // 16 data blocks, threshold 0
    lo0 = low_cnt;
    do_start(16, 0);
    wait_valid();
    chk("w16_low_cycles", low_cnt - lo0, 17);
    chk("w16_blocks", o_res_blocks, 16);
    chk("w16_data", o_res_data, 16);
    chk("w16_inv", o_res_inv, 0);
    chk("w16_pass", o_pass, 1);
    chk("w16_mis", o_mismatch, 0);
    handshake();

    // 8 blocks with two corrupted, threshold 1 then 2
    kind[2] = 2'd2; kind[5] = 2'd2;
    do_start(8, 1);
    wait_valid();
    chk("w8t1_inv", o_res_inv, 2);
    chk("w8t1_pass", o_pass, 0);
    chk("w8t1_mis", o_mismatch, 0);
    handshake();
    do_start(8, 2);
    wait_valid();
    chk("w8t2_inv", o_res_inv, 2);
    chk("w8t2_pass", o_pass, 1);
    handshake();
    clr_kinds();

    // Report held for 10 cycles with stray start/abort pulses
    kind[1] = 2'd1;
    do_start(4, 0);
    wait_valid();
    for (int k = 0; k < 10; k++) begin
      i_start = k[0];
      i_abort = (k == 5);
      @(negedge clk);
      chk("hold_valid", o_result_valid, 1);
      chk("hold_ctrl", o_res_ctrl, 1);
      chk("hold_data", o_res_data, 3);
    end
    i_start = 1'b0; i_abort = 1'b0;
    handshake();
    clr_kinds();

    // Abort in RUN cycle 3 of 16
    a0 = ab_cnt;
    do_start(16, 0);
    repeat (4) @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    chk("abort_pulse", o_aborted, 1);
    chk("abort_busy", o_busy, 0);
    chk("abort_chk_rst", o_chk_rst, 1);
    chk("abort_res_kept", o_res_blocks, 4);
    chk("abort_no_valid", o_result_valid, 0);
    @(negedge clk);
    chk("abort_once", ab_cnt - a0, 1);

    // Abort during CLEAR
    do_start(5, 0);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    chk("abort_clear_busy", o_busy, 0);
    @(negedge clk);

    // Zero length runs as one block
    do_start(0, 0);
    wait_valid();
    chk("len0_blocks", o_res_blocks, 1);
    chk("len0_pass", o_pass, 1);
    handshake();

    // Unclassified block gives a data+ctrl mismatch
    kind[3] = 2'd3;
    do_start(6, 5);
    wait_valid();
    chk("mis_data", o_res_data, 5);
    chk("mis_flag", o_mismatch, 1);
    chk("mis_pass", o_pass, 0);
    handshake();
    clr_kinds();

    // Start and abort together in IDLE: start wins
    i_abort = 1'b1;
    do_start(3, 0);
    i_abort = 1'b0;
    chk("startabort_busy", o_busy, 1);
    wait_valid();
    chk("startabort_blocks", o_res_blocks, 3);
    handshake();

    // Reset mid-RUN
    a0 = ab_cnt;
    do_start(16, 0);
    repeat (4) @(negedge clk);
    #2 i_rst_n = 1'b0;
    #1;
    chk("mrst_chk_rst", o_chk_rst, 1);
    chk("mrst_busy", o_busy, 0);
    chk("mrst_valid", o_result_valid, 0);
    chk("mrst_res_blocks", o_res_blocks, 0);
    chk("mrst_aborted", o_aborted, 0);
    @(negedge clk);
    i_rst_n = 1'b1;
    @(negedge clk);
    do_start(5, 0);
    wait_valid();
    chk("post_rst_blocks", o_res_blocks, 5);
    chk("post_rst_pass", o_pass, 1);
    handshake();
    chk("mrst_no_abort", ab_cnt - a0, 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
